// File: rtl/mips_pkg.sv
// ============================================================================
// Module  : mips_pkg
// Brief   : R-type opcode/funct encodings, instruction field positions and
//           the execution-controller state type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'b000000;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;
  localparam int SH_MSB = 10;
  localparam int SH_LSB = 6;
  localparam int FN_MSB = 5;
  localparam int FN_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  function automatic logic is_legal_rtype(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    if (op == OP_RTYPE) begin
      case (fn)
        FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLL,
        FUNCT_SRL, FUNCT_SRA, FUNCT_SLLV, FUNCT_SLT: ok = 1'b1;
        default:                                     ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic is_addsub(input logic [5:0] fn);
    return (fn == FUNCT_ADD) || (fn == FUNCT_SUB);
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_2r1w.sv
// ============================================================================
// Module  : regfile_2r1w
// Brief   : 32x32 register file, two operand reads plus a debug read, one
//           synchronous write with $0 hard-wired to zero, async clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_2r1w #(
  parameter int NREG = 32,
  parameter int W    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_we,
  input  logic [$clog2(NREG)-1:0] i_waddr,
  input  logic [W-1:0]            i_wdata,
  input  logic [$clog2(NREG)-1:0] i_raddr_a,
  output logic [W-1:0]            o_rdata_a,
  input  logic [$clog2(NREG)-1:0] i_raddr_b,
  output logic [W-1:0]            o_rdata_b,
  input  logic [$clog2(NREG)-1:0] i_raddr_d,
  output logic [W-1:0]            o_rdata_d
);

  logic [W-1:0] r_mem [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];
  assign o_rdata_d = r_mem[i_raddr_d];

endmodule

`default_nettype wire

// File: rtl/rtype_exec_ctrl.sv
// ============================================================================
// Module  : rtype_exec_ctrl
// Brief   : Four-state (IDLE/READ/EXEC/WB) R-type controller feeding an
//           external combinational ALU and writing results back to the RF.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rtype_exec_ctrl
  import mips_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic        ld_valid,
  input  logic [4:0]  ld_addr,
  input  logic [31:0] ld_data,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic [5:0]  alu_funct,
  output logic [4:0]  alu_shamt,
  output logic [31:0] alu_rs,
  output logic [31:0] alu_rt,
  input  logic [31:0] alu_result,
  input  logic        alu_carry,
  input  logic        alu_zero,
  input  logic        alu_ovf,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        done,
  output logic [2:0]  flags,
  output logic        err_illegal,
  output logic        err_overflow
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_instr;
  logic [31:0] r_res;
  logic [2:0]  r_cap_flags;
  logic [2:0]  r_flags;
  logic        r_err_ill;
  logic        r_err_ovf;
  logic [5:0]  r_alu_funct;
  logic [4:0]  r_alu_shamt;
  logic [31:0] r_alu_rs;
  logic [31:0] r_alu_rt;

  logic        w_accept;
  logic        w_ld_en;
  logic        w_wb_en;
  logic        w_done;
  logic        w_ready;
  logic [31:0] w_rf_a;
  logic [31:0] w_rf_b;

  wire  [5:0]  w_op    = r_instr[OP_MSB:OP_LSB];
  wire  [4:0]  w_rs    = r_instr[RS_MSB:RS_LSB];
  wire  [4:0]  w_rt    = r_instr[RT_MSB:RT_LSB];
  wire  [4:0]  w_rd    = r_instr[RD_MSB:RD_LSB];
  wire  [4:0]  w_sh    = r_instr[SH_MSB:SH_LSB];
  wire  [5:0]  w_fn    = r_instr[FN_MSB:FN_LSB];
  wire         w_legal = is_legal_rtype(w_op, w_fn);
  wire         w_as    = w_legal && is_addsub(w_fn);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    w_ld_en     = 1'b0;
    w_wb_en     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready  = 1'b1;
        // Preload wins the cycle; the offered word simply waits.
        w_ld_en  = ld_valid;
        w_accept = instr_valid && !ld_valid;
        if (w_accept) w_state_nxt = ST_READ;
      end
      ST_READ: w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_WB;
      ST_WB: begin
        w_done      = 1'b1;
        w_wb_en     = w_legal && (w_rd != 5'd0) && !(w_as && r_cap_flags[0]);
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr     <= '0;
      r_res       <= '0;
      r_cap_flags <= '0;
      r_flags     <= '0;
      r_err_ill   <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_alu_funct <= '0;
      r_alu_shamt <= '0;
      r_alu_rs    <= '0;
      r_alu_rt    <= '0;
    end else begin
      if (w_accept) r_instr <= instr;
      if (r_state == ST_READ) begin
        r_alu_rs    <= w_rf_a;
        r_alu_rt    <= w_rf_b;
        r_alu_funct <= w_fn;
        r_alu_shamt <= w_sh;
      end
      if (r_state == ST_EXEC) begin
        r_res       <= alu_result;
        r_cap_flags <= {alu_carry, alu_zero, alu_ovf};
      end
      if (r_state == ST_WB) begin
        r_flags <= r_cap_flags;
        if (!w_legal)                r_err_ill <= 1'b1;
        if (w_as && r_cap_flags[0])  r_err_ovf <= 1'b1;
      end
    end
  end

  // Preload and writeback never overlap: one is IDLE-only, the other WB-only.
  regfile_2r1w #(.NREG(NREG), .W(32)) u_rf (
    .clk       (clk),
    .rst       (reset),
    .i_we      (w_wb_en || w_ld_en),
    .i_waddr   (w_wb_en ? w_rd : ld_addr),
    .i_wdata   (w_wb_en ? r_res : ld_data),
    .i_raddr_a (w_rs),
    .o_rdata_a (w_rf_a),
    .i_raddr_b (w_rt),
    .o_rdata_b (w_rf_b),
    .i_raddr_d (dbg_addr),
    .o_rdata_d (dbg_data)
  );

  assign instr_ready  = w_ready;
  assign done         = w_done;
  assign wb_valid     = w_wb_en;
  assign wb_addr      = w_wb_en ? w_rd : 5'd0;
  assign wb_data      = w_wb_en ? r_res : 32'd0;
  assign flags        = r_flags;
  assign err_illegal  = r_err_ill;
  assign err_overflow = r_err_ovf;
  assign alu_funct    = r_alu_funct;
  assign alu_shamt    = r_alu_shamt;
  assign alu_rs       = r_alu_rs;
  assign alu_rt       = r_alu_rt;

endmodule

`default_nettype wire

// File: tb/tb_rtype_exec_ctrl.sv
// ============================================================================
// Module  : tb_rtype_exec_ctrl
// Brief   : Directed, table-driven bench for rtype_exec_ctrl with a small
//           behavioural ALU model closing the loop.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rtype_exec_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        ld_valid;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [5:0]  alu_funct;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_rs;
  logic [31:0] alu_rt;
  logic [31:0] alu_result;
  logic        alu_carry;
  logic        alu_zero;
  logic        alu_ovf;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        done;
  logic [2:0]  flags;
  logic        err_illegal;
  logic        err_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rtype_exec_ctrl #(.NREG(32)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_data(ld_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .alu_funct(alu_funct), .alu_shamt(alu_shamt), .alu_rs(alu_rs),
    .alu_rt(alu_rt), .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_zero(alu_zero), .alu_ovf(alu_ovf), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data), .done(done), .flags(flags),
    .err_illegal(err_illegal), .err_overflow(err_overflow)
  );

  // Behavioural stand-in for aluModul; subtract carry means "no borrow".
  logic [32:0] m_sum;
  always_comb begin
    m_sum      = '0;
    alu_result = '0;
    alu_carry  = 1'b0;
    alu_ovf    = 1'b0;
    case (alu_funct)
      6'b100000: begin
        m_sum      = {1'b0, alu_rs} + {1'b0, alu_rt};
        alu_result = m_sum[31:0];
        alu_carry  = m_sum[32];
        alu_ovf    = (alu_rs[31] == alu_rt[31]) && (m_sum[31] != alu_rs[31]);
      end
      6'b100010: begin
        m_sum      = {1'b0, alu_rs} + {1'b0, ~alu_rt} + 33'd1;
        alu_result = m_sum[31:0];
        alu_carry  = m_sum[32];
        alu_ovf    = (alu_rs[31] != alu_rt[31]) && (m_sum[31] != alu_rs[31]);
      end
      6'b100100: alu_result = alu_rs & alu_rt;
      6'b100101: alu_result = alu_rs | alu_rt;
      6'b000000: alu_result = alu_rt << alu_shamt;
      6'b000010: alu_result = alu_rt >> alu_shamt;
      6'b000011: alu_result = $signed(alu_rt) >>> alu_shamt;
      6'b000100: alu_result = alu_rt << alu_rs[4:0];
      6'b101010: alu_result = {31'd0, $signed(alu_rs) < $signed(alu_rt)};
      default:   alu_result = '0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  typedef struct {
    logic [4:0]  pa;   logic [31:0] pda;
    logic [4:0]  pb;   logic [31:0] pdb;
    logic [31:0] ins;
    logic        ewb;  logic [31:0] erd;  logic [2:0] efl;
    logic [31:0] ert;  logic [4:0]  esh;
    logic        eill; logic        eovf;
  } vec_t;

  vec_t tv [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic issue(input logic [31:0] w, input bit inj_ld,
                       output bit got_wb, output int wb_lat, output int done_lat,
                       output logic [4:0] wa, output logic [31:0] wd,
                       output logic [31:0] a_rt, output logic [4:0] a_sh);
    got_wb = 1'b0; wb_lat = -1; done_lat = -1; wa = '0; wd = '0; a_rt = '0; a_sh = '0;
    @(negedge clk);
    instr = w; instr_valid = 1'b1;
    for (int c = 1; c <= 10 && done_lat < 0; c++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      if (inj_ld) begin
        ld_valid = (c < 3); ld_addr = 5'd9; ld_data = 32'hDEAD_BEEF;
      end
      if (c == 2) begin a_rt = alu_rt; a_sh = alu_shamt; end
      if (wb_valid && !got_wb) begin got_wb = 1'b1; wb_lat = c; wa = wb_addr; wd = wb_data; end
      if (done) done_lat = c;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          gw;
    int          wl, dl, acc1, acc2, ndone, nz;
    logic [4:0]  wa, sh, rdx;
    logic [31:0] wd, rt, ins;

    tv[0]  = '{5'd1, 32'hFFFFFFFF, 5'd2, 32'h0000000F, 32'h00221820, 1'b1, 32'h0000000E, 3'b100, 32'h0000000F, 5'd0, 1'b0, 1'b0};
    tv[1]  = '{5'd1, 32'h00000000, 5'd2, 32'hFFFFFFFA, 32'h00022103, 1'b1, 32'hFFFFFFFF, 3'b000, 32'hFFFFFFFA, 5'd4, 1'b0, 1'b0};
    tv[2]  = '{5'd1, 32'hFFFFFFFC, 5'd6, 32'h00000004, 32'h0026282A, 1'b1, 32'h00000001, 3'b000, 32'h00000004, 5'd0, 1'b0, 1'b0};
    tv[3]  = '{5'd1, 32'hFFFFFFFC, 5'd6, 32'h00000004, 32'h00C1282A, 1'b1, 32'h00000000, 3'b010, 32'hFFFFFFFC, 5'd0, 1'b0, 1'b0};
    tv[4]  = '{5'd1, 32'hF0F0FF00, 5'd2, 32'h0FF0F0F0, 32'h00223824, 1'b1, 32'h00F0F000, 3'b000, 32'h0FF0F0F0, 5'd0, 1'b0, 1'b0};
    tv[5]  = '{5'd1, 32'h00000000, 5'd2, 32'h12345678, 32'h00024200, 1'b1, 32'h34567800, 3'b000, 32'h12345678, 5'd8, 1'b0, 1'b0};
    tv[6]  = '{5'd1, 32'h00000005, 5'd2, 32'h00000005, 32'h00225022, 1'b1, 32'h00000000, 3'b110, 32'h00000005, 5'd0, 1'b0, 1'b0};
    tv[7]  = '{5'd1, 32'h00000000, 5'd2, 32'h80000000, 32'h00025902, 1'b1, 32'h08000000, 3'b000, 32'h80000000, 5'd4, 1'b0, 1'b0};
    tv[8]  = '{5'd1, 32'h00000003, 5'd2, 32'h00000001, 32'h00226004, 1'b1, 32'h00000008, 3'b000, 32'h00000001, 5'd0, 1'b0, 1'b0};
    tv[9]  = '{5'd1, 32'h00FF0000, 5'd2, 32'h0000FF00, 32'h00226825, 1'b1, 32'h00FFFF00, 3'b000, 32'h0000FF00, 5'd0, 1'b0, 1'b0};
    tv[10] = '{5'd1, 32'h00000005, 5'd2, 32'h00000006, 32'h00220020, 1'b0, 32'h00000000, 3'b000, 32'h00000006, 5'd0, 1'b0, 1'b0};
    tv[11] = '{5'd1, 32'h7FFFFFFF, 5'd2, 32'h00000001, 32'h00221020, 1'b0, 32'h00000001, 3'b001, 32'h00000001, 5'd0, 1'b0, 1'b1};
    tv[12] = '{5'd1, 32'h00000001, 5'd2, 32'h00000002, 32'h0022183F, 1'b0, 32'h0000000E, 3'b010, 32'h00000002, 5'd0, 1'b1, 1'b1};
    tv[13] = '{5'd1, 32'h00000001, 5'd2, 32'h00000002, 32'h04221820, 1'b0, 32'h0000000E, 3'b000, 32'h00000002, 5'd0, 1'b1, 1'b1};

    reset = 1'b1; instr_valid = 1'b0; instr = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset instr_ready", {31'd0, instr_ready}, 32'd1);
    check("reset done/wb_valid", {30'd0, done, wb_valid}, 32'd0);
    check("reset flags/errs", {27'd0, flags, err_illegal, err_overflow}, 32'd0);

    preload(5'd0, 32'h00001234);
    dbg_addr = 5'd0; #1;
    check("preload r0 ignored", dbg_data, 32'd0);

    for (int i = 0; i < 14; i++) begin
      preload(tv[i].pa, tv[i].pda);
      preload(tv[i].pb, tv[i].pdb);
      ins = tv[i].ins;
      rdx = ins[15:11];
      issue(tv[i].ins, 1'b0, gw, wl, dl, wa, wd, rt, sh);
      check($sformatf("v%0d wb_valid", i), {31'd0, gw}, {31'd0, tv[i].ewb});
      if (tv[i].ewb) begin
        check($sformatf("v%0d wb latency", i), wl, 32'd3);
        check($sformatf("v%0d wb_addr", i), {27'd0, wa}, {27'd0, rdx});
        check($sformatf("v%0d wb_data", i), wd, tv[i].erd);
      end
      check($sformatf("v%0d done latency", i), dl, 32'd3);
      check($sformatf("v%0d alu_rt", i), rt, tv[i].ert);
      check($sformatf("v%0d alu_shamt", i), {27'd0, sh}, {27'd0, tv[i].esh});
      check($sformatf("v%0d flags", i), {29'd0, flags}, {29'd0, tv[i].efl});
      check($sformatf("v%0d err_illegal", i), {31'd0, err_illegal}, {31'd0, tv[i].eill});
      check($sformatf("v%0d err_overflow", i), {31'd0, err_overflow}, {31'd0, tv[i].eovf});
      check($sformatf("v%0d instr_ready", i), {31'd0, instr_ready}, 32'd1);
      dbg_addr = rdx; #1;
      check($sformatf("v%0d rf[rd]", i), dbg_data, tv[i].erd);
    end

    // Two words offered back to back with instr_valid held high.
    preload(5'd1, 32'd10);
    preload(5'd2, 32'd20);
    @(negedge clk);
    instr = 32'h00221820; instr_valid = 1'b1;
    acc1 = -1; acc2 = -1; ndone = 0;
    for (int t = 0; t < 20 && ndone < 2; t++) begin
      if (instr_valid && instr_ready) begin
        if (acc1 < 0) acc1 = t; else acc2 = t;
      end
      @(negedge clk);
      if (done) ndone++;
      if (acc2 >= 0) instr_valid = 1'b0;
      else if (acc1 >= 0) instr = 32'h00612020;
    end
    check("b2b both retired", ndone, 32'd2);
    check("b2b accept spacing", acc2 - acc1, 32'd4);
    @(negedge clk);
    dbg_addr = 5'd3; #1;
    check("b2b first result", dbg_data, 32'd30);
    dbg_addr = 5'd4; #1;
    check("b2b dependent result", dbg_data, 32'd40);

    // Preload attempts while busy must not land.
    preload(5'd9, 32'h00001111);
    issue(32'h00223824, 1'b1, gw, wl, dl, wa, wd, rt, sh);
    dbg_addr = 5'd9; #1;
    check("ld while busy ignored", dbg_data, 32'h00001111);

    // Reset in the middle of EXEC.
    preload(5'd1, 32'd1);
    preload(5'd2, 32'd2);
    @(negedge clk);
    instr = 32'h00221820; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1; #1;
    check("midreset instr_ready", {31'd0, instr_ready}, 32'd1);
    check("midreset wb_valid/done", {30'd0, wb_valid, done}, 32'd0);
    check("midreset flags/errs", {27'd0, flags, err_illegal, err_overflow}, 32'd0);
    check("midreset alu_rs", alu_rs, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    nz = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (wb_valid || done) nz++;
    end
    check("midreset no writeback", nz, 32'd0);
    check("midreset idle", {31'd0, instr_ready}, 32'd1);
    nz = 0;
    for (int a = 0; a < 32; a++) begin
      dbg_addr = a[4:0]; #1;
      if (dbg_data != 32'd0) nz++;
    end
    check("midreset rf cleared", nz, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
